// File: rtl/ibex_lsu_resp_align.sv
// LSU response stage: tracks one (possibly split) bus transaction, merges/aligns beats, extends load data.
// Optional macro IBEX_LSU_RESP_REG_OUT_EN registers the writeback-facing outputs (1-cycle latency).
module ibex_lsu_resp_align #(
  parameter bit ResetAll = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [1:0]  req_type_i,
  input  logic        req_sign_ext_i,
  input  logic [1:0]  req_offset_i,
  input  logic        req_split_i,
  output logic        ready_o,
  output logic        busy_o,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i,
  output logic [31:0] rf_wdata_lsu_o,
  output logic        rf_we_lsu_o,
  output logic        lsu_resp_valid_o,
  output logic        lsu_resp_err_o
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    WAIT_LAST  = 2'd2
  } state_e;

  state_e      state_r;
  logic        err_r;
  logic        we_r;
  logic [1:0]  type_r;
  logic        sign_ext_r;
  logic [1:0]  offset_r;
  logic [23:0] rdata_r;

  logic        final_beat_s;
  logic        accept_s;
  logic        first_beat_s;
  logic [15:0] half_s;
  logic [7:0]  byte_s;
  logic [31:0] aligned_s;
  logic [31:0] wdata_s;
  logic        resp_valid_s;
  logic        resp_err_s;
  logic        rf_we_s;

  assign final_beat_s = (state_r == WAIT_LAST) & data_rvalid_i;
  assign first_beat_s = (state_r == WAIT_FIRST) & data_rvalid_i;
  assign ready_o      = (state_r == IDLE) | final_beat_s;
  assign accept_s     = req_valid_i & ready_o;
  assign busy_o       = (state_r != IDLE);

  // Transaction FSM and sticky first-beat error flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r <= req_split_i ? WAIT_FIRST : WAIT_LAST;
            err_r   <= 1'b0;
          end
        end
        WAIT_FIRST: begin
          if (data_rvalid_i) begin
            state_r <= WAIT_LAST;
            err_r   <= data_err_i;
          end
        end
        WAIT_LAST: begin
          if (data_rvalid_i) begin
            if (req_valid_i) begin
              state_r <= req_split_i ? WAIT_FIRST : WAIT_LAST;
              err_r   <= 1'b0;
            end else begin
              state_r <= IDLE;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          err_r   <= 1'b0;
        end
      endcase
    end
  end

  // Request attributes and first-beat data; reset only when ResetAll is set
  if (ResetAll) begin : g_data_rst
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        we_r       <= 1'b0;
        type_r     <= 2'b00;
        sign_ext_r <= 1'b0;
        offset_r   <= 2'b00;
        rdata_r    <= 24'h000000;
      end else begin
        if (accept_s) begin
          we_r       <= req_we_i;
          type_r     <= req_type_i;
          sign_ext_r <= req_sign_ext_i;
          offset_r   <= req_offset_i;
        end
        if (first_beat_s) begin
          rdata_r <= data_rdata_i[31:8];
        end
      end
    end
  end else begin : g_data_norst
    always_ff @(posedge clk_i) begin
      if (accept_s) begin
        we_r       <= req_we_i;
        type_r     <= req_type_i;
        sign_ext_r <= req_sign_ext_i;
        offset_r   <= req_offset_i;
      end
      if (first_beat_s) begin
        rdata_r <= data_rdata_i[31:8];
      end
    end
  end

  // Beat merge, alignment and extension; offset alone selects split vs. aligned forms
  always_comb begin
    half_s    = 16'h0000;
    byte_s    = 8'h00;
    aligned_s = 32'h00000000;
    case (offset_r)
      2'd0:    half_s = data_rdata_i[15:0];
      2'd1:    half_s = data_rdata_i[23:8];
      2'd2:    half_s = data_rdata_i[31:16];
      2'd3:    half_s = {data_rdata_i[7:0], rdata_r[23:16]};
      default: half_s = 16'h0000;
    endcase
    case (offset_r)
      2'd0:    byte_s = data_rdata_i[7:0];
      2'd1:    byte_s = data_rdata_i[15:8];
      2'd2:    byte_s = data_rdata_i[23:16];
      2'd3:    byte_s = data_rdata_i[31:24];
      default: byte_s = 8'h00;
    endcase
    case (type_r)
      2'b01:   aligned_s = {{16{sign_ext_r & half_s[15]}}, half_s};
      2'b10:   aligned_s = {{24{sign_ext_r & byte_s[7]}}, byte_s};
      default: begin
        case (offset_r)
          2'd0:    aligned_s = data_rdata_i;
          2'd1:    aligned_s = {data_rdata_i[7:0], rdata_r[23:0]};
          2'd2:    aligned_s = {data_rdata_i[15:0], rdata_r[23:8]};
          2'd3:    aligned_s = {data_rdata_i[23:0], rdata_r[23:16]};
          default: aligned_s = data_rdata_i;
        endcase
      end
    endcase
  end

  assign resp_valid_s = final_beat_s;
  assign resp_err_s   = resp_valid_s & (err_r | data_err_i);
  assign rf_we_s      = resp_valid_s & ~we_r & ~resp_err_s;

  // Write data is driven only for a completing load
  always_comb begin
    wdata_s = 32'h00000000;
    if (resp_valid_s && !we_r) begin
      wdata_s = aligned_s;
    end else begin
      wdata_s = 32'h00000000;
    end
  end

`ifdef IBEX_LSU_RESP_REG_OUT_EN
  // Registered writeback outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_wdata_lsu_o   <= 32'h00000000;
      rf_we_lsu_o      <= 1'b0;
      lsu_resp_valid_o <= 1'b0;
      lsu_resp_err_o   <= 1'b0;
    end else begin
      rf_wdata_lsu_o   <= wdata_s;
      rf_we_lsu_o      <= rf_we_s;
      lsu_resp_valid_o <= resp_valid_s;
      lsu_resp_err_o   <= resp_err_s;
    end
  end
`else
  assign rf_wdata_lsu_o   = wdata_s;
  assign rf_we_lsu_o      = rf_we_s;
  assign lsu_resp_valid_o = resp_valid_s;
  assign lsu_resp_err_o   = resp_err_s;
`endif

endmodule
